// File: rtl/display_scan_bcd_pkg.sv
// Shared constants for the display scan path: converter FSM encodings, the blank nibble
// and the per-nibble add-3 correction used by the sequential binary-to-BCD converter.
package display_scan_bcd_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // Decoder renders this nibble with every segment off.
  localparam logic [3:0] BCD_BLANK = 4'hF;

  function automatic logic [3:0] bcd_adjust(input logic [3:0] nib);
    return (nib >= 4'd5) ? nib + 4'd3 : nib;
  endfunction

endpackage

// File: rtl/display_scan_bcd_bin2bcd_seq.sv
// Sequential shift-and-add-3 converter; done pulses WIDTH+1 cycles after an accepted load.
// No backpressure: loads arriving while busy are dropped, digits update atomically with done.
module bin2bcd_seq
  import display_scan_bcd_pkg::*;
#(
  parameter int WIDTH  = 10,
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [WIDTH-1:0]    value,
  input  logic                load,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] digits
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [1:0]                  state;
  logic [WIDTH-1:0]            bin;
  logic [4*DIGITS-1:0]         acc;
  logic [4*DIGITS-1:0]         acc_adj;
  logic [CW-1:0]               cnt;
  logic [4*DIGITS+WIDTH-1:0]   shifted;

  always_comb begin
    acc_adj = acc;
    for (int i = 0; i < DIGITS; i++) begin
      acc_adj[4*i +: 4] = bcd_adjust(acc[4*i +: 4]);
    end
    shifted = {acc_adj, bin} << 1;
  end

  assign busy = (state == ST_SHIFT) || (state == ST_DONE);
  assign done = (state == ST_DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      bin    <= '0;
      acc    <= '0;
      cnt    <= '0;
      digits <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (load) begin
            bin   <= value;
            acc   <= '0;
            cnt   <= CW'(WIDTH);
            state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          acc <= shifted[4*DIGITS+WIDTH-1:WIDTH];
          bin <= shifted[WIDTH-1:0];
          cnt <= cnt - CW'(1);
          // Final shift lands straight in the digit registers so they are valid while done is high.
          if (cnt == CW'(1)) begin
            digits <= shifted[4*DIGITS+WIDTH-1:WIDTH];
            state  <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/display_scan_bcd.sv
// Converts a loaded binary value to BCD and time-multiplexes the digits onto bcd/an.
// Scan never stalls; new loads while converting are ignored, display swaps atomically on done.
module display_scan_bcd
  import display_scan_bcd_pkg::*;
#(
  parameter int WIDTH         = 10,
  parameter int DIGITS        = 4,
  parameter int REFRESH_DIV   = 100000,
  parameter int LEADING_BLANK = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  value,
  input  logic              load,
  output logic              busy,
  output logic              done,
  output logic [3:0]        bcd,
  output logic [DIGITS-1:0] an
);

  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [4*DIGITS-1:0] digits;
  logic [RW-1:0]       rcnt;
  logic [IW-1:0]       idx;
  logic [3:0]          dig [DIGITS];
  logic [DIGITS-1:0]   blank;
  logic                lead;

  bin2bcd_seq #(
    .WIDTH  (WIDTH),
    .DIGITS (DIGITS)
  ) u_conv (
    .clk    (clk),
    .rst_n  (rst_n),
    .value  (value),
    .load   (load),
    .busy   (busy),
    .done   (done),
    .digits (digits)
  );

  // Walk from the top digit down; a digit is blanked while everything above it is still zero.
  always_comb begin
    lead  = 1'b1;
    blank = '0;
    dig   = '{default: 4'd0};
    for (int i = DIGITS - 1; i >= 0; i--) begin
      dig[i]   = digits[4*i +: 4];
      lead     = lead & (digits[4*i +: 4] == 4'd0);
      blank[i] = (LEADING_BLANK != 0) && (i > 0) && lead;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rcnt <= '0;
      idx  <= '0;
      an   <= '1;
      bcd  <= BCD_BLANK;
    end else begin
      if (rcnt == RW'(REFRESH_DIV - 1)) begin
        rcnt <= '0;
        idx  <= (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
      end else begin
        rcnt <= rcnt + RW'(1);
      end
      an  <= ~(DIGITS'(1) << idx);
      bcd <= blank[idx] ? BCD_BLANK : dig[idx];
    end
  end

endmodule

// File: tb/tb_display_scan_bcd.sv
// Randomised and directed bench for display_scan_bcd against a decimal-arithmetic reference model.
module tb_display_scan_bcd;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] value = '0;
  logic       load = 1'b0;
  logic       busy;
  logic       done;
  logic [3:0] bcd;
  logic [3:0] an;

  int checks = 0;
  int errors = 0;

  // Reference model state: edges since reset release, accepted-load edge, shown and pending values.
  int n_edge   = 0;
  int acc_edge = -1;
  int pend_val = 0;
  int reg_val  = 0;
  int done_cnt = 0;

  display_scan_bcd #(
    .WIDTH         (10),
    .DIGITS        (4),
    .REFRESH_DIV   (4),
    .LEADING_BLANK (1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .value (value),
    .load  (load),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd),
    .an    (an)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d, t=%0t)", tag, obs, exp, n_edge, $time);
    end
  endtask

  function automatic int pow10(input int e);
    int p = 1;
    for (int k = 0; k < e; k++) p = p * 10;
    return p;
  endfunction

  // Digit i of v in decimal, or 4'hF when it is a leading zero above the units digit.
  function automatic logic [3:0] shown_digit(input int v, input int i);
    if (i > 0 && v < pow10(i)) return 4'hF;
    return 4'((v / pow10(i)) % 10);
  endfunction

  task automatic step(input logic r, input logic l, input logic [9:0] v);
    int          pre_val;
    bit          was_busy;
    logic [3:0]  exp_an;
    logic [3:0]  exp_bcd;
    bit          exp_busy;
    bit          exp_done;
    int          slot;
    rst_n = r;
    load  = l;
    value = v;
    @(posedge clk);
    #1;
    if (!r) begin
      n_edge   = 0;
      acc_edge = -1;
      reg_val  = 0;
      exp_an   = 4'b1111;
      exp_bcd  = 4'hF;
      exp_busy = 1'b0;
      exp_done = 1'b0;
    end else begin
      pre_val  = reg_val;
      was_busy = (acc_edge >= 0) && (n_edge - 1 <= acc_edge + 10);
      if (!was_busy) acc_edge = -1;
      if (acc_edge >= 0 && n_edge == acc_edge + 10) reg_val = pend_val;
      if (!was_busy && l) begin
        acc_edge = n_edge;
        pend_val = int'(v);
      end
      exp_busy = (acc_edge >= 0) && (n_edge <= acc_edge + 10);
      exp_done = (acc_edge >= 0) && (n_edge == acc_edge + 10);
      slot     = (n_edge / 4) % 4;
      exp_an   = ~(4'b0001 << slot);
      exp_bcd  = shown_digit(pre_val, slot);
      n_edge++;
    end
    if (done === 1'b1) done_cnt++;
    chk("an", 32'(an), 32'(exp_an));
    chk("bcd", 32'(bcd), 32'(exp_bcd));
    chk("busy", 32'(busy), 32'(exp_busy));
    chk("done", 32'(done), 32'(exp_done));
  endtask

  task automatic idle(input int cycles);
    for (int c = 0; c < cycles; c++) step(1'b1, 1'b0, 10'($urandom));
  endtask

  initial begin
    int dc;
    // Reset held three cycles, then a plain scan of the reset digits.
    for (int c = 0; c < 3; c++) step(1'b0, 1'b0, 10'd0);
    idle(20);

    // Full-scale value, then a full refresh frame.
    dc = done_cnt;
    step(1'b1, 1'b1, 10'd1023);
    idle(30);
    chk("done_pulses_1023", 32'(done_cnt - dc), 32'd1);

    step(1'b1, 1'b1, 10'd100);
    idle(30);
    step(1'b1, 1'b1, 10'd7);
    idle(30);

    // Second load during conversion must be dropped.
    dc = done_cnt;
    step(1'b1, 1'b1, 10'd500);
    idle(1);
    step(1'b1, 1'b1, 10'd9);
    idle(30);
    chk("done_pulses_busy_load", 32'(done_cnt - dc), 32'd1);

    // Reload mid-scan: old digits until done, then new ones.
    step(1'b1, 1'b1, 10'd1023);
    idle(20);
    step(1'b1, 1'b1, 10'd42);
    idle(30);

    // Reset in the middle of a conversion aborts it without a done pulse.
    dc = done_cnt;
    step(1'b1, 1'b1, 10'd999);
    idle(4);
    step(1'b0, 1'b0, 10'd0);
    idle(30);
    chk("done_pulses_abort", 32'(done_cnt - dc), 32'd0);

    // Random loads with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 499) == 0) step(1'b0, 1'b0, 10'($urandom));
      else step(1'b1, ($urandom_range(0, 15) == 0), 10'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/display_scan_bcd.md
Name: display_scan_bcd

Overview:
- Upstream feeder for the BCD-to-7-segment decoder in the display path.
- Accepts a binary value (e.g. PWM duty or count) on a load strobe and converts it to BCD sequentially using shift-and-add-3.
- Time-multiplexes the resulting digits onto a shared 4-bit bcd bus while driving active-low anodes.
- Blanked digits are driven as 4'hF, which the decoder renders as all segments off.

Parameters:
- WIDTH, 10, binary input width; the maximum value is 1023, which fits in DIGITS.
- DIGITS, 4, number of displayed digits and anodes.
- REFRESH_DIV, 100000, clk cycles per digit slot (1 kHz per digit at 100 MHz).
- LEADING_BLANK, 1, when 1, leading zero digits are blanked.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- value  input  WIDTH  binary value to display.
- load  input  1  one-cycle strobe; captures value when idle.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when the new digits take effect.
- bcd  output  4  digit nibble to the decoder; 4'hF when blanked.
- an  output  DIGITS  anode enables, active low, one-hot.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-low on rst_n, sampled on the clk rising edge; there is no asynchronous path.
- Reset values:
  - an = all ones; bcd = 4'hF; busy = 0; done = 0.
  - Digit registers = 0; scan index = 0; refresh counter = 0; FSM = IDLE.
- Conversion FSM, states IDLE, SHIFT, DONE:
  - IDLE: when load=1, capture value into the shift register, clear the BCD accumulator, set bit counter = WIDTH, go to SHIFT, busy=1 from the next cycle.
  - SHIFT: each cycle, add 3 to every BCD nibble that is >=5, then shift {bcd_acc, bin} left by 1 and decrement the counter. After WIDTH shift cycles, go to DONE.
  - DONE: copy bcd_acc into the digit registers atomically, done=1 for this cycle only, busy=0 next cycle, return to IDLE.
  - Latency: load sampled at edge k gives done=1 in cycle k+WIDTH+1 (cycle 11 for WIDTH=10).
  - load while busy is ignored; there is no queueing.
  - value is sampled only at the accepting edge.
- Scan:
  - The refresh counter free-runs from 0 to REFRESH_DIV-1. At the terminal count it wraps to 0 and the index advances, wrapping from DIGITS-1 to 0.
  - Scanning runs continuously, including during conversion, and shows the old digits until DONE.
  - an and bcd are registered and update in the same cycle after an index change, so there is no ghosting. an = ~(1<<index).
- Blanking, when LEADING_BLANK=1:
  - Digit i (i>0) is driven as 4'hF if it and every higher digit are 0.
  - Digit 0 is never blanked; zeros between nonzero digits are shown.
  - Blanking is evaluated on the digit registers, not on bcd_acc.
- Reset mid-conversion aborts: FSM goes to IDLE, digits go to 0, and done does not pulse.
- The anode remains asserted for blanked digits; the segment pattern alone turns the digit off.

Decomposition:
- Shared Verilog include (display_defs.vh):
  - FSM state encodings (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2).
  - BCD_BLANK = 4'hF.
  - ANODE_OFF = all ones.
- Natural sub-module: bin2bcd_seq (FSM plus shift/add-3 datapath, with load/busy/done and a packed digit output).
- The scan counter, index, blanking and anode logic stay in display_scan_bcd.

Test Plan (REFRESH_DIV=4, WIDTH=10, DIGITS=4):
1. Hold rst_n=0 for 3 cycles -> an=4'b1111, bcd=4'hF, busy=0, done=0. After release, an steps 1110, 1101, 1011, 0111, 1110 every 4 cycles; bcd = 0, F, F, F.
2. load=1 with value=1023 -> busy high for 11 cycles and done pulses exactly at cycle 11. Scan then shows bcd 3, 2, 0, 1 for index 0..3.
3. value=100 -> bcd 0, 0, 1, F (inner zeros shown, top digit blanked). value=7 -> 7, F, F, F.
4. load 500, then load 9 two cycles later while busy -> the second load is ignored; exactly one done pulse; display 0, 0, 5, F.
5. During the scan of 1023, load 42 -> the old digits persist until the done cycle, then switch atomically to 2, 4, F, F with no mixed frame.
6. rst_n=0 at SHIFT cycle 5 of a conversion of 999 -> busy=0 next cycle, no done pulse, display returns to 0, F, F, F.
